// File: rtl/sim_ctrl_pkg.sv
// Shared state encoding and TOHOST protocol constants for the simulation controller.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_TMO  = 2'd3
  } state_e;

  // A TOHOST store terminates the test only when its LSB is set; the rest is the exit code.
  localparam int TOHOST_FLAG_BIT = 0;
  localparam int EXIT_SHIFT      = 1;

endpackage

// File: rtl/sim_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset and a synchronous clear.
module sim_ctrl_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: sequences core reset, counts RUN cycles, snoops TOHOST stores, runs a watchdog.
// Optional retired-instruction counter and its ports exist only when SIM_CTRL_INSTRET_EN is defined.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int            AW             = 32,
  parameter int            DW             = 32,
  parameter int            CW             = 32,
  parameter int            RST_CYCLES     = 4,
  parameter int            TIMEOUT_CYCLES = 100000,
  parameter logic [AW-1:0] TOHOST_ADDR    = 32'h8000_1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mon_valid,
  input  logic          mon_we,
  input  logic [AW-1:0] mon_addr,
  input  logic [DW-1:0] mon_wdata,
  output logic          core_rst_n,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [DW-1:0] exit_code,
  output logic [CW-1:0] cycle_cnt
`ifdef SIM_CTRL_INSTRET_EN
  ,
  input  logic          retire_valid,
  output logic [CW-1:0] instret_cnt
`endif
);

  localparam int            HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q,      state_d;
  logic [HW-1:0] hold_cnt_q,   hold_cnt_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          pass_q,       pass_d;
  logic [DW-1:0] exit_code_q,  exit_code_d;

  logic in_hold;
  logic in_run;
  logic term_store;
  logic wd_expire;

  assign in_hold    = (state_q == S_HOLD);
  assign in_run     = (state_q == S_RUN);
  assign term_store = mon_valid & mon_we & (mon_addr == TOHOST_ADDR) & mon_wdata[TOHOST_FLAG_BIT];
  assign wd_expire  = (cycle_cnt == WD_LAST);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pass_d      = pass_q;
    exit_code_d = exit_code_q;
    unique case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // A terminating store outranks watchdog expiry on the same edge.
        if (term_store) begin
          state_d     = S_DONE;
          exit_code_d = mon_wdata >> EXIT_SHIFT;
          pass_d      = ((mon_wdata >> EXIT_SHIFT) == '0);
        end else if (wd_expire) begin
          state_d = S_TMO;
        end
      end
      default: begin
        // DONE and TMO hold until rst_n; the core keeps running.
      end
    endcase
    core_rst_n_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      core_rst_n_q <= 1'b0;
      pass_q       <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      pass_q       <= pass_d;
      exit_code_q  <= exit_code_d;
    end
  end

  sim_ctrl_sat_cnt #(.W(CW)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_hold),
    .inc   (in_run),
    .q     (cycle_cnt)
  );

`ifdef SIM_CTRL_INSTRET_EN
  sim_ctrl_sat_cnt #(.W(CW)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_hold),
    .inc   (in_run & retire_valid),
    .q     (instret_cnt)
  );
`endif

  assign core_rst_n = core_rst_n_q;
  assign done       = (state_q == S_DONE);
  assign timeout    = (state_q == S_TMO);
  assign pass       = pass_q;
  assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// Randomised bench for sim_ctrl against an edge-counting reference model, plus directed scenario checks.
module tb_sim_ctrl;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          CW  = 32;
  localparam int          RST = 4;
  localparam int          TMO = 50;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mon_valid;
  logic          mon_we;
  logic [AW-1:0] mon_addr;
  logic [DW-1:0] mon_wdata;
  logic          retire_valid;
  logic          core_rst_n;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [DW-1:0] exit_code;
  logic [CW-1:0] cycle_cnt;
`ifdef SIM_CTRL_INSTRET_EN
  logic [CW-1:0] instret_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: edges seen since reset release, terminal flags, counters.
  int          m_edges;
  bit          m_done;
  bit          m_tmo;
  bit          m_pass;
  int unsigned m_exit;
  int unsigned m_cyc;
  int unsigned m_ins;

  always #5 clk = ~clk;

  sim_ctrl #(
    .AW(AW), .DW(DW), .CW(CW),
    .RST_CYCLES(RST), .TIMEOUT_CYCLES(TMO), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mon_valid    (mon_valid),
    .mon_we       (mon_we),
    .mon_addr     (mon_addr),
    .mon_wdata    (mon_wdata),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .exit_code    (exit_code),
    .cycle_cnt    (cycle_cnt)
`ifdef SIM_CTRL_INSTRET_EN
    ,
    .retire_valid (retire_valid),
    .instret_cnt  (instret_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_step();
    bit running;
    if (!rst_n) begin
      m_edges = 0;
      m_done  = 1'b0;
      m_tmo   = 1'b0;
      m_pass  = 1'b0;
      m_exit  = 0;
      m_cyc   = 0;
      m_ins   = 0;
    end else begin
      running = (m_edges >= RST) && !m_done && !m_tmo;
      if (m_edges < RST) m_edges++;
      if (running) begin
        if (mon_valid && mon_we && mon_addr == TOHOST && mon_wdata[0]) begin
          m_done = 1'b1;
          m_exit = mon_wdata >> 1;
          m_pass = (m_exit == 0);
        end else if (m_cyc == TMO - 1) begin
          m_tmo = 1'b1;
        end
        m_cyc++;
        if (retire_valid) m_ins++;
      end
    end
  endtask

  // Advance one edge and compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("core_rst_n", core_rst_n, (m_edges >= RST));
    check("done", done, m_done);
    check("pass", pass, m_pass);
    check("timeout", timeout, m_tmo);
    check("exit_code", exit_code, m_exit);
    check("cycle_cnt", cycle_cnt, m_cyc);
`ifdef SIM_CTRL_INSTRET_EN
    check("instret_cnt", instret_cnt, m_ins);
`endif
  endtask

  task automatic rand_bus(input int term_pct);
    mon_valid    = 1'($urandom_range(0, 1));
    mon_we       = 1'($urandom_range(0, 1));
    mon_addr     = ($urandom_range(0, 2) == 0) ? TOHOST : $urandom;
    mon_wdata    = $urandom_range(0, 15);
    if ($urandom_range(0, 99) >= term_pct) mon_wdata[0] = 1'b0;
    retire_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic store(input logic [31:0] d);
    mon_valid = 1'b1;
    mon_we    = 1'b1;
    mon_addr  = TOHOST;
    mon_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_bus(50);
    tick();
    check("rst_core", core_rst_n, 1'b0);
    check("rst_cyc", cycle_cnt, 0);
  endtask

  // Release reset with terminating-looking stores flying during HOLD; they must be ignored.
  task automatic release_hold(input string tag);
    rst_n = 1'b1;
    for (int i = 1; i <= RST; i++) begin
      store(32'h5);
      tick();
      if (i == RST - 1) check({tag, "_held"}, core_rst_n, 1'b0);
      if (i == RST) check({tag, "_up"}, core_rst_n, 1'b1);
    end
    check({tag, "_cyc0"}, cycle_cnt, 0);
    check({tag, "_nodone"}, done, 1'b0);
  endtask

  task automatic run_to(input int n);
    int g = 0;
    while (m_cyc < n && g < 200) begin
      rand_bus(0);
      tick();
      g++;
    end
    check("run_to_cyc", cycle_cnt, n);
  endtask

  initial begin
    rst_n = 1'b0;
    rand_bus(0);
    tick();
    do_reset();

    // Passing test at RUN cycle 20; later store must not alter status.
    release_hold("a");
    run_to(20);
    store(32'h1);
    tick();
    check("a_done", done, 1'b1);
    check("a_pass", pass, 1'b1);
    check("a_exit", exit_code, 0);
    check("a_cyc", cycle_cnt, 21);
    store(32'h7);
    tick();
    check("a_frozen", cycle_cnt, 21);

    // Failing exit code, then ignored second store.
    do_reset();
    release_hold("b");
    run_to(10);
    store(32'h7);
    tick();
    check("b_exit", exit_code, 3);
    check("b_pass", pass, 1'b0);
    store(32'h1);
    tick();
    check("b_exit_kept", exit_code, 3);

    // Watchdog with a non-terminating TOHOST store along the way.
    do_reset();
    release_hold("c");
    run_to(5);
    store(32'h2);
    tick();
    check("c_even_ignored", done, 1'b0);
    run_to(TMO - 1);
    check("c_not_yet", timeout, 1'b0);
    rand_bus(0);
    tick();
    check("c_tmo", timeout, 1'b1);
    check("c_tmo_done", done, 1'b0);
    check("c_tmo_cyc", cycle_cnt, TMO);
    store(32'h1);
    tick();
    check("c_late_store", done, 1'b0);

    // Store on the watchdog-expiry edge wins.
    do_reset();
    release_hold("d");
    run_to(TMO - 1);
    store(32'h1);
    tick();
    check("d_done", done, 1'b1);
    check("d_tmo", timeout, 1'b0);

    // Mid-run reset pulse clears everything and repeats HOLD.
    do_reset();
    release_hold("e");
    run_to(10);
    do_reset();
    release_hold("e2");

    // Retire counting: 10 of 15 RUN cycles.
    do_reset();
    release_hold("f");
    for (int i = 0; i < 15; i++) begin
      rand_bus(0);
      retire_valid = (i % 3 != 0);
      tick();
    end
`ifdef SIM_CTRL_INSTRET_EN
    check("f_instret", instret_cnt, 10);
`endif

    // Random soak with sporadic resets and terminations.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      rand_bus(3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
